// File: rtl/uart_baud_nco.sv
// uart_baud_nco: fractional phase-accumulator UART baud generator with oversample, tx bit and rx mid-bit strobes
// Ports:
//   sys_clk, rst      clock and synchronous active-high reset
//   en                run enable; when low all state holds and strobes drop
//   inc_wr, inc_in    load a new phase increment
//   rx_sync           start-bit pulse, restarts the rx sample counter
//   inc_q             phase increment currently in use
//   over_tick         oversample strobe (BAUDRATE*OVS)
//   tx_tick           tx bit strobe, one per OVS over_ticks
//   rx_sample         rx mid-bit strobe
//   tx_clk, rx_clk    debug toggles on tx_tick / over_tick
module uart_baud_nco #(
   parameter int SYS_CLK  = 30000000,
   parameter int BAUDRATE = 9600,
   parameter int OVS      = 16,
   parameter int ACC_W    = 24
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             inc_wr,
   input  logic [ACC_W-1:0] inc_in,
   input  logic             rx_sync,
   output logic [ACC_W-1:0] inc_q,
   output logic             over_tick,
   output logic             tx_tick,
   output logic             rx_sample,
   output logic             tx_clk,
   output logic             rx_clk
);
   localparam int CW = $clog2(OVS);
   localparam logic [63:0] DEF_INC_64 =
      (64'(BAUDRATE) * 64'(OVS) * (64'd1 << ACC_W) + 64'(SYS_CLK) / 64'd2) / 64'(SYS_CLK);
   localparam logic [ACC_W-1:0] DEF_INC = DEF_INC_64[ACC_W-1:0];
   localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
   localparam logic [CW-1:0] RX_MID   = CW'(OVS / 2 - 1);
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_inc;
   logic [CW-1:0]    r_tx_cnt;
   logic [CW-1:0]    r_rx_cnt;
   logic             r_over_tick;
   logic             r_tx_tick;
   logic             r_rx_sample;
   logic             r_tx_clk;
   logic             r_rx_clk;
   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic             w_tx_wrap;
   logic             w_rx_wrap;
   logic             w_rx_mid;
   // the carry out of the accumulator is the oversample event; gated by en so hold freezes everything
   assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
   assign w_carry   = en & w_sum[ACC_W];
   assign w_tx_wrap = r_tx_cnt == CNT_LAST;
   assign w_rx_wrap = r_rx_cnt == CNT_LAST;
   assign w_rx_mid  = r_rx_cnt == RX_MID;
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_inc       <= DEF_INC;
         r_tx_cnt    <= '0;
         r_rx_cnt    <= '0;
         r_over_tick <= 1'b0;
         r_tx_tick   <= 1'b0;
         r_rx_sample <= 1'b0;
         r_tx_clk    <= 1'b0;
         r_rx_clk    <= 1'b0;
      end else begin
         r_acc       <= en ? w_sum[ACC_W-1:0] : r_acc;
         r_inc       <= inc_wr ? inc_in : r_inc;
         r_over_tick <= w_carry;
         r_tx_tick   <= w_carry & w_tx_wrap;
         // a carry landing on the sync edge is swallowed: the counter restarts instead
         r_rx_sample <= w_carry & w_rx_mid & ~rx_sync;
         r_tx_cnt    <= w_carry ? (w_tx_wrap ? '0 : r_tx_cnt + 1'b1) : r_tx_cnt;
         r_rx_cnt    <= rx_sync ? '0 : w_carry ? (w_rx_wrap ? '0 : r_rx_cnt + 1'b1) : r_rx_cnt;
         r_tx_clk    <= r_tx_clk ^ (w_carry & w_tx_wrap);
         r_rx_clk    <= r_rx_clk ^ w_carry;
      end
   end
   assign inc_q     = r_inc;
   assign over_tick = r_over_tick;
   assign tx_tick   = r_tx_tick;
   assign rx_sample = r_rx_sample;
   assign tx_clk    = r_tx_clk;
   assign rx_clk    = r_rx_clk;
endmodule

// File: tb/tb_uart_baud_nco.sv
// tb_uart_baud_nco: randomized and directed checks of uart_baud_nco against a phase-count reference model
module tb_uart_baud_nco;
   localparam int ACC_W = 24;
   localparam int OVS   = 16;
   localparam logic [23:0] DEF = 24'd85899;
   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        inc_wr = 1'b0;
   logic        rx_sync = 1'b0;
   logic [23:0] inc_in = '0;
   logic [23:0] inc_q;
   logic        over_tick, tx_tick, rx_sample, tx_clk, rx_clk;
   int checks = 0;
   int errors = 0;
   longint p = 0;
   longint ntick = 0;
   longint since = 0;
   logic [23:0] m_inc = DEF;
   logic e_over = 1'b0, e_tx = 1'b0, e_rx = 1'b0;
   uart_baud_nco #(.SYS_CLK(30000000), .BAUDRATE(9600), .OVS(OVS), .ACC_W(ACC_W)) dut (
      .sys_clk(sys_clk), .rst(rst), .en(en), .inc_wr(inc_wr), .inc_in(inc_in), .rx_sync(rx_sync),
      .inc_q(inc_q), .over_tick(over_tick), .tx_tick(tx_tick), .rx_sample(rx_sample),
      .tx_clk(tx_clk), .rx_clk(rx_clk)
   );
   always #5 sys_clk = ~sys_clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // total phase p counts every increment ever added; an oversample tick is a crossing of a 2^ACC_W boundary
   task automatic model_edge();
      logic carry;
      if (rst) begin
         p = 0; ntick = 0; since = 0; m_inc = DEF;
         e_over = 0; e_tx = 0; e_rx = 0;
      end else begin
         carry = en && (((p + longint'(m_inc)) >> ACC_W) != (p >> ACC_W));
         if (en) p = p + longint'(m_inc);
         if (carry) ntick++;
         e_over = carry;
         e_tx = carry && (ntick % OVS == 0);
         if (rx_sync) begin
            since = 0;
            e_rx = 0;
         end else begin
            if (carry) since++;
            e_rx = carry && (since % OVS == OVS / 2);
         end
         if (inc_wr) m_inc = inc_in;
      end
   endtask
   task automatic step();
      @(posedge sys_clk);
      model_edge();
      #1;
      chk("cycle", {inc_q, over_tick, tx_tick, rx_sample, tx_clk, rx_clk},
          {m_inc, e_over, e_tx, e_rx, ((ntick / OVS) % 2) == 1, (ntick % 2) == 1});
      inc_wr = 1'b0;
      rx_sync = 1'b0;
   endtask
   initial begin
      int c, t, n;
      logic got, prev;
      logic [23:0] picks [3];
      picks[0] = 24'h800000; picks[1] = DEF; picks[2] = 24'hFFFFFF;
      step(); step();
      chk("rst_inc", inc_q, DEF);
      chk("rst_out", {over_tick, tx_tick, rx_sample, tx_clk, rx_clk}, 0);
      rst = 0; en = 1; n = 0; got = 0;
      for (int i = 1; i <= 1000 && !got; i++) begin
         step();
         if (over_tick) begin got = 1; n = i; end
      end
      chk("first_tick", n, 196);
      inc_in = 24'h800000; inc_wr = 1; step();
      chk("inc_set", inc_q, 24'h800000);
      c = 0;
      for (int i = 0; i < 64; i++) begin step(); c += int'(over_tick); end
      chk("rate_over", c, 32);
      c = 0; t = 0;
      for (int i = 0; i < 512; i++) begin
         prev = tx_clk; step(); c += int'(tx_tick); t += int'(tx_clk != prev);
      end
      chk("rate_tx", c, 16);
      chk("rate_txclk", t, 16);
      rx_sync = 1; step();
      c = 0; got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         step(); c += int'(over_tick); got = rx_sample;
      end
      chk("rx_first", c, 8);
      n = 0; got = 0;
      for (int i = 0; i < 100 && !got; i++) begin step(); n++; got = rx_sample; end
      chk("rx_period", n, 32);
      for (int i = 0; i < 4 && over_tick; i++) step();
      rx_sync = 1; step();
      chk("sync_carry", {over_tick, rx_sample}, 2'b10);
      c = 0; got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         step(); c += int'(over_tick); got = rx_sample;
      end
      chk("rx_restart", c, 8);
      en = 0; c = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin inc_in = 24'h400000; inc_wr = 1; end
         if (i == 70) rx_sync = 1;
         step(); c += int'(over_tick | tx_tick | rx_sample);
      end
      chk("hold_strobes", c, 0);
      chk("hold_inc", inc_q, 24'h400000);
      en = 1;
      for (int i = 0; i < 200; i++) step();
      inc_in = 24'h0; inc_wr = 1; step(); c = 0;
      for (int i = 0; i < 10000; i++) begin step(); c += int'(over_tick | tx_tick | rx_sample); end
      chk("zero_inc", c, 0);
      inc_in = 24'hFFFFFF; inc_wr = 1; step(); c = 0;
      for (int i = 0; i < 300; i++) begin step(); c += int'(over_tick); end
      chk("max_inc", c >= 299, 1);
      rst = 1; inc_wr = 1; inc_in = 24'h123456; rx_sync = 1; step();
      chk("mid_rst_inc", inc_q, DEF);
      chk("mid_rst_out", {over_tick, tx_tick, rx_sample, tx_clk, rx_clk}, 0);
      rst = 0; c = 0; t = 0;
      for (int i = 0; i < 60000; i++) begin step(); c += int'(over_tick); t += int'(tx_tick); end
      chk("long_over", c, (longint'(60000) * 85899) >> 24);
      chk("long_tx", t, ((longint'(60000) * 85899) >> 24) / OVS);
      for (int i = 0; i < 5000; i++) begin
         en = ($urandom % 8) != 0;
         rx_sync = ($urandom % 40) == 0;
         inc_wr = ($urandom % 200) == 0;
         n = $urandom % 4;
         inc_in = n == 3 ? 24'($urandom) : picks[n];
         rst = ($urandom % 1000) == 0;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
